// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, FSM states and default width.
// Imported by the execution unit, its shifter and the control decoder.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_SLL = 4'b0101,
        ALU_SRL = 4'b0110,
        ALU_SLT = 4'b0111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } alu_state_e;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle of the execution-stage ALU.
// The slave side is the ALU; the master side issues ops and takes results.
interface alu_exec_unit_if #(
    parameter int XLEN = alu_pkg::XLEN_DEFAULT
);
    logic            valid_i;
    logic            ready_o;
    logic [3:0]      control_line_i;
    logic [XLEN-1:0] operand_a_i;
    logic [XLEN-1:0] operand_b_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] result_o;
    logic            zero_o;
    logic            illegal_o;

    modport master (
        output valid_i, control_line_i,
        output operand_a_i, operand_b_i,
        output ready_i,
        input  ready_o, valid_o,
        input  result_o, zero_o, illegal_o
    );

    modport slave (
        input  valid_i, control_line_i,
        input  operand_a_i, operand_b_i,
        input  ready_i,
        output ready_o, valid_o,
        output result_o, zero_o, illegal_o
    );
endinterface

// File: rtl/alu_shift_iter.sv
// One-bit-per-cycle logical shifter; runs while cnt is nonzero.
// done flags the cycle whose edge applies the final shift.
module alu_shift_iter #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load,
    input  logic            left,
    input  logic [XLEN-1:0] data,
    input  logic [SHW-1:0]  amt,
    output logic [XLEN-1:0] shifted,
    output logic            done
);
    logic [XLEN-1:0] sreg;
    logic [SHW-1:0]  cnt;
    logic            left_q;

    assign shifted = left_q ? {sreg[XLEN-2:0], 1'b0}
                            : {1'b0, sreg[XLEN-1:1]};
    assign done    = (cnt == SHW'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sreg   <= '0;
            cnt    <= '0;
            left_q <= 1'b0;
        end else if (load) begin
            sreg   <= data;
            cnt    <= amt;
            left_q <= left;
        end else if (cnt != '0) begin
            sreg <= shifted;
            cnt  <= cnt - SHW'(1);
        end
    end
endmodule

// File: rtl/alu_exec_unit.sv
// Execution-stage ALU: single-cycle logic/arith ops plus iterative shifts,
// registered result and flags behind valid/ready handshakes.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    alu_exec_unit_if.slave bus
);
    alu_state_e      state;
    logic [XLEN-1:0] a, b;
    logic [XLEN-1:0] alu_res, fast_res, sh_res, res_q;
    logic [SHW-1:0]  shamt;
    logic            illegal, is_shift, fast_path;
    logic            sh_load, sh_left, sh_done;
    logic            valid_q, zero_q, illegal_q;

    assign a     = bus.operand_a_i;
    assign b     = bus.operand_b_i;
    assign shamt = b[SHW-1:0];

    always_comb begin
        alu_res  = '0;
        illegal  = 1'b0;
        is_shift = 1'b0;
        case (bus.control_line_i)
            ALU_AND: alu_res = a & b;
            ALU_OR:  alu_res = a | b;
            ALU_ADD: alu_res = a + b;
            ALU_SUB: alu_res = a - b;
            ALU_XOR: alu_res = a ^ b;
            ALU_SLL: is_shift = 1'b1;
            ALU_SRL: is_shift = 1'b1;
            ALU_SLT: alu_res = {{(XLEN-1){1'b0}},
                                $signed(a) < $signed(b)};
            default: illegal = 1'b1;
        endcase
    end

    // A zero-length shift completes like any single-cycle op.
    assign fast_path = !is_shift || (shamt == '0);
    assign fast_res  = is_shift ? a : alu_res;
    assign sh_load   = (state == ST_IDLE) && bus.valid_i && is_shift;
    assign sh_left   = (bus.control_line_i == ALU_SLL);

    alu_shift_iter #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_shift (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load    (sh_load),
        .left    (sh_left),
        .data    (a),
        .amt     (shamt),
        .shifted (sh_res),
        .done    (sh_done)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            valid_q   <= 1'b0;
            res_q     <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.valid_i) begin
                        if (fast_path) begin
                            res_q     <= fast_res;
                            zero_q    <= (fast_res == '0);
                            illegal_q <= illegal;
                            valid_q   <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (sh_done) begin
                        res_q     <= sh_res;
                        zero_q    <= (sh_res == '0);
                        illegal_q <= 1'b0;
                        valid_q   <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.ready_i) begin
                        valid_q <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ready_o   = (state == ST_IDLE);
    assign bus.valid_o   = valid_q;
    assign bus.result_o  = res_q;
    assign bus.zero_o    = zero_q;
    assign bus.illegal_o = illegal_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized and directed bench for alu_exec_unit against an
// arithmetic reference model, with latency, stall and reset checks.
module tb_alu_exec_unit;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    alu_exec_unit_if #(.XLEN(32)) bus ();

    alu_exec_unit #(.XLEN(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return a + b;
            4'd3: return a - b;
            4'd4: return a ^ b;
            4'd5: return a << b[4:0];
            4'd6: return a >> b[4:0];
            4'd7: return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic run_op(input logic [3:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input int stall,
                          output logic [31:0] res);
        logic [31:0] exp;
        int exp_lat;
        int cyc;
        exp = ref_alu(op, a, b);
        exp_lat = 0;
        if ((op == 4'd5 || op == 4'd6) && b[4:0] != 5'd0)
            exp_lat = int'(b[4:0]);
        @(negedge clk);
        check("ready_idle", bus.ready_o, 1);
        bus.ready_i        = (stall == 0);
        bus.valid_i        = 1'b1;
        bus.control_line_i = op;
        bus.operand_a_i    = a;
        bus.operand_b_i    = b;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        check("ready_busy", bus.ready_o, 0);
        cyc = 0;
        while (!bus.valid_o && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency", cyc, exp_lat);
        check("result", bus.result_o, exp);
        check("zero", bus.zero_o, exp == 32'd0);
        check("illegal", bus.illegal_o, op[3]);
        res = bus.result_o;
        if (stall > 0) begin
            bus.valid_i        = 1'b1;
            bus.control_line_i = 4'd2;
            bus.operand_a_i    = $urandom;
            bus.operand_b_i    = $urandom;
            repeat (stall) begin
                @(posedge clk);
                #1;
                check("stall_valid", bus.valid_o, 1);
                check("stall_result", bus.result_o, exp);
                check("stall_ready", bus.ready_o, 0);
            end
            @(negedge clk);
            bus.ready_i = 1'b1;
        end
        @(posedge clk);
        #1;
        check("deliver_valid", bus.valid_o, 0);
        check("deliver_ready", bus.ready_o, 1);
        bus.valid_i = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        logic [3:0]  op;
        logic [31:0] a, b;
        int          st;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.valid_i        = 1'b1;
        bus.ready_i        = 1'b1;
        bus.control_line_i = 4'd2;
        bus.operand_a_i    = 32'd7;
        bus.operand_b_i    = 32'd9;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", bus.valid_o, 0);
        check("rst_ready", bus.ready_o, 1);
        check("rst_result", bus.result_o, 0);
        check("rst_zero", bus.zero_o, 1);
        check("rst_illegal", bus.illegal_o, 0);
        @(negedge clk);
        bus.valid_i = 1'b0;
        rst = 1'b0;

        run_op(4'd2, 32'h7FFF_FFFF, 32'd1, 0, r);
        check("add_ovf", r, 32'h8000_0000);
        run_op(4'd3, 32'd5, 32'd5, 0, r);
        check("sub_eq", r, 32'd0);
        check("sub_zero", bus.zero_o, 1);
        run_op(4'd7, 32'hFFFF_FFFF, 32'd1, 0, r);
        check("slt_neg", r, 32'd1);
        run_op(4'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, r);
        check("and_pat", r, 32'h00F0_00F0);
        run_op(4'd1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, r);
        check("or_pat", r, 32'hFFF0_FFF0);
        run_op(4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, r);
        check("xor_pat", r, 32'hFF00_FF00);
        run_op(4'd5, 32'd1, 32'h0000_0024, 0, r);
        check("sll_4", r, 32'h10);
        run_op(4'd6, 32'h8000_0000, 32'd31, 0, r);
        check("srl_31", r, 32'd1);
        run_op(4'd5, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 0, r);
        check("sll_0", r, 32'hDEAD_BEEF);
        run_op(4'd2, 32'h1234_5678, 32'h1111_1111, 5, r);
        check("stall_add", r, 32'h2345_6789);
        run_op(4'b1010, 32'd3, 32'd3, 0, r);
        check("illegal_res", r, 32'd0);
        run_op(4'd2, 32'd3, 32'd3, 0, r);
        check("illegal_clr", bus.illegal_o, 0);
        run_op(4'd6, 32'hF000_000F, 32'd8, 3, r);

        @(negedge clk);
        bus.ready_i        = 1'b1;
        bus.valid_i        = 1'b1;
        bus.control_line_i = 4'd6;
        bus.operand_a_i    = 32'hFFFF_0000;
        bus.operand_b_i    = 32'd20;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", bus.valid_o, 0);
        check("arst_ready", bus.ready_o, 1);
        check("arst_result", bus.result_o, 0);
        check("arst_zero", bus.zero_o, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("arst_dropped", bus.valid_o, 0);
        run_op(4'd2, 32'd40, 32'd2, 0, r);
        check("arst_add", r, 32'd42);

        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 3))
                0: a = 32'h8000_0000;
                1: b = a;
                default: ;
            endcase
            st = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
            run_op(op, a, b, st, r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execution-stage ALU that consumes the 4-bit control line produced by the ALU control decoder, plus two operands, and returns a registered result with zero and illegal flags. Logic ops, ADD, SUB and SLT complete in one cycle. SLL and SRL run on an iterative one-bit-per-cycle shifter. Input and output use valid/ready handshakes, so the pipeline stalls while a shift is in progress.

## Interface
- XLEN, 32: operand and result width.
- SHW, $clog2(XLEN): shift-amount width.
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- valid_i  input  1  request valid.
- ready_o  output  1  unit can accept a request; high only in IDLE.
- control_line_i  input  4  operation code: 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SLT; 1xxx illegal.
- operand_a_i  input  XLEN  rs1 value.
- operand_b_i  input  XLEN  rs2 or immediate value; bits [SHW-1:0] give the shift amount.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts the result.
- result_o  output  XLEN  registered result.
- zero_o  output  1  result_o == 0; used by the branch logic after SUB.
- illegal_o  output  1  the completed request carried a 1xxx code.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- ready_o = (state == IDLE).
- A request is accepted on a rising edge where valid_i && ready_o. While rst_i is high, valid_i is ignored.
- IDLE, non-shift op accepted:
  - result_o, zero_o and illegal_o are registered.
  - State goes to DONE.
- IDLE, SLL/SRL accepted:
  - operand_a_i loads into the shift register.
  - cnt loads operand_b_i[SHW-1:0].
  - If cnt == 0, the unit goes directly to DONE with result_o = operand_a_i. Otherwise it goes to SHIFT.
- SHIFT:
  - Each cycle: shift by 1 (SLL shifts left and fills with 0; SRL shifts right logically and fills with 0), then cnt decrements.
  - When cnt reaches 1, the final shift is taken, result_o is written and state goes to DONE.
- DONE:
  - valid_o = 1.
  - result_o and the flags hold stable until ready_i == 1.
  - On the handshake edge, state goes to IDLE.
  - The unit never accepts a request in the same cycle that it delivers one.
- Arithmetic and width rules:
  - ADD and SUB wrap modulo 2^XLEN; no carry or overflow outputs.
  - SLT is a signed compare. Result is {XLEN-1 zeros, a<b}.
  - Shift amounts use only the low SHW bits of operand_b_i; upper bits are ignored.
- Illegal code (1xxx): result_o = 0, zero_o = 1, illegal_o = 1. Latency and handshake are the same as a legal single-cycle op.
- Reset (asynchronous; takes effect mid-shift or mid-DONE):
  - state = IDLE, valid_o = 0, result_o = 0, zero_o = 1, illegal_o = 0, cnt = 0.
  - Any in-flight operation is dropped with no output.

## Timing
- Single-cycle op accepted at edge N: valid_o is high from edge N onward (visible in cycle N+1).
- Shift by k (1..XLEN-1) accepted at edge N: valid_o rises at edge N+k. Shift by 0 behaves like a single-cycle op.
- Back-to-back throughput, with ready_i tied high: one single-cycle op every 2 cycles (accept, then deliver).
- ready_i held low in DONE: indefinite stall; outputs do not change.
- All outputs are registered except ready_o, which decodes state only and has no input-to-output combinational path.

## Structure
- Shared package alu_pkg holds:
  - typedef enum logic [3:0] alu_ctrl_e, with the codes above (shared with the ALU control decoder).
  - The FSM state enum.
  - Default XLEN.
- Sub-module alu_shift_iter holds the shift register, cnt, direction and done pulse. The parent FSM sequences it.
- Combinational single-cycle datapath and flag logic stay in alu_exec_unit.

## Test plan
- ADD: a=0x7FFF_FFFF, b=1, ready_i=1 -> valid_o one cycle later, result 0x8000_0000, zero_o=0. SUB: a=b=5 -> result 0, zero_o=1.
- SLT: a=0xFFFF_FFFF, b=1 -> result 1. Then AND/OR/XOR on 0xF0F0_F0F0 and 0x0FF0_0FF0 -> 0x00F0_00F0, 0xFFF0_FFF0, 0xFF00_FF00.
- SLL: a=1, b=0x0000_0024 (shamt 4) -> ready_o low for 4 cycles, valid_o at edge N+4, result 0x10. SRL: a=0x8000_0000, shamt 31 -> result 1. shamt 0 -> 1-cycle result equal to a.
- Backpressure: complete an op with ready_i=0 for 5 cycles -> valid_o and result_o stable, ready_o=0, and a new valid_i is not accepted until the handshake edge.
- Illegal code 1010 with a=b=3 -> result 0, zero_o=1, illegal_o=1. The next legal op clears illegal_o.
- Reset asserted asynchronously mid-shift (shamt 20, cycle 7) -> immediate IDLE, valid_o=0, result_o=0. After release, a new ADD completes normally.
